// File: rtl/biu_arbiter_pkg.sv
// rtl/biu_arbiter_pkg.sv - shared types and constants for the BIU arbiter
//
// Holds the arbiter FSM state encoding, the requester index constants and
// the BIU select code used by the instruction fetch path.
package biu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int unsigned NREQ = 3;

  // Requester indices: bit position in req/lock/gnt/done.
  localparam logic [1:0] REQ_FCU = 2'd0;
  localparam logic [1:0] REQ_EXU = 2'd1;
  localparam logic [1:0] REQ_PER = 2'd2;

  // BIU select code for an instruction fetch.
  localparam logic [1:0] SEL_FETCH = 2'b11;

  // One-hot requester vector to index; zero maps to FCU (callers only use
  // the result when the vector is non-zero).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    case (oh)
      3'b010:  return REQ_EXU;
      3'b100:  return REQ_PER;
      default: return REQ_FCU;
    endcase
  endfunction

endpackage

// File: rtl/biu_arbiter_rr_pick.sv
// rtl/biu_arbiter_rr_pick.sv - combinational round-robin winner select
//
// Ports:
//   req_i        [2:0]  active requests
//   last_owner_i [1:0]  index of the previous owner; search starts one past it
//   winner_o     [2:0]  one-hot winner, zero when no request is active
import biu_arbiter_pkg::*;

module rr_pick (
  input  logic [2:0] req_i,
  input  logic [1:0] last_owner_i,
  output logic [2:0] winner_o
);

  always_comb begin
    winner_o = 3'b000;
    case (last_owner_i)
      REQ_FCU: begin
        if      (req_i[1]) winner_o = 3'b010;
        else if (req_i[2]) winner_o = 3'b100;
        else if (req_i[0]) winner_o = 3'b001;
      end
      REQ_EXU: begin
        if      (req_i[2]) winner_o = 3'b100;
        else if (req_i[0]) winner_o = 3'b001;
        else if (req_i[1]) winner_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) winner_o = 3'b001;
        else if (req_i[1]) winner_o = 3'b010;
        else if (req_i[2]) winner_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/biu_arbiter.sv
// rtl/biu_arbiter.sv - three-requester round-robin arbiter for a single BIU
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i, lock_i  [2:0]   per-requester request / keep-grant-for-next-beat
//   sel_req_i      [5:0]   2-bit BIU select per requester
//   addr_req_i     [47:0]  16-bit address per requester
//   ready_biu_i, bus_i     BIU beat-complete strobe and read data
//   cs_biu_o, sel_biu_o, addr_biu_o  BIU request side
//   gnt_o, done_o  [2:0]   one-hot owner, one-cycle completion pulse
//   err_o                  one-cycle timeout abort pulse
//   rdata_o        [15:0]  bus value captured at beat completion
//   busy_o                 FSM not idle
import biu_arbiter_pkg::*;

module biu_arbiter #(
  parameter int TIMEOUT   = 16,
  parameter int BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  req_i,
  input  logic [2:0]  lock_i,
  input  logic [5:0]  sel_req_i,
  input  logic [47:0] addr_req_i,
  input  logic        ready_biu_i,
  input  logic [15:0] bus_i,
  output logic        cs_biu_o,
  output logic [1:0]  sel_biu_o,
  output logic [15:0] addr_biu_o,
  output logic [2:0]  gnt_o,
  output logic [2:0]  done_o,
  output logic        err_o,
  output logic [15:0] rdata_o,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  state_e         state_q;
  logic           cs_q;
  logic [1:0]     sel_q;
  logic [15:0]    addr_q;
  logic [2:0]     gnt_q;
  logic [2:0]     done_q;
  logic           err_q;
  logic [15:0]    rdata_q;
  logic           busy_q;
  logic [1:0]     last_q;
  logic [BW-1:0]  beats_q;
  logic [TW-1:0]  tmo_q;

  logic [2:0]     pick_d;
  logic [1:0]     pick_idx;
  logic [1:0]     owner_idx;

  rr_pick u_rr_pick (
    .req_i        (req_i),
    .last_owner_i (last_q),
    .winner_o     (pick_d)
  );

  assign pick_idx  = onehot_to_idx(pick_d);
  assign owner_idx = onehot_to_idx(gnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= REQ_PER;
      beats_q <= '0;
      tmo_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cs_q  <= 1'b0;
          gnt_q <= '0;
          if (|req_i) begin
            gnt_q   <= pick_d;
            sel_q   <= sel_req_i[{pick_idx, 1'b0} +: 2];
            addr_q  <= addr_req_i[{pick_idx, 4'b0000} +: 16];
            cs_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_biu_i) begin
            rdata_q <= bus_i;
            done_q  <= gnt_q;
            beats_q <= beats_q + BW'(1);
            cs_q    <= 1'b0;
            state_q <= ST_HOLD;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            // Counter hits TIMEOUT on this edge: abort without touching rdata.
            if (tmo_q == TW'(TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              cs_q    <= 1'b0;
              gnt_q   <= '0;
              beats_q <= '0;
              last_q  <= owner_idx;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (lock_i[owner_idx] && (beats_q < BW'(BURST_MAX))) begin
            sel_q   <= sel_req_i[{owner_idx, 1'b0} +: 2];
            addr_q  <= addr_req_i[{owner_idx, 4'b0000} +: 16];
            cs_q    <= 1'b1;
            state_q <= ST_ISSUE;
          end else begin
            // Recording the owner makes it rank last in the next search.
            last_q  <= owner_idx;
            gnt_q   <= '0;
            beats_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          cs_q    <= 1'b0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cs_biu_o   = cs_q;
  assign sel_biu_o  = sel_q;
  assign addr_biu_o = addr_q;
  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// tb/tb_biu_arbiter.sv - scoreboard bench for biu_arbiter
import biu_arbiter_pkg::*;

module tb_biu_arbiter;

  localparam int TIMEOUT   = 16;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  lock = '0;
  logic        ready_en = 1'b1;
  logic [1:0]  sel_arr  [3];
  logic [15:0] addr_arr [3];
  logic [5:0]  sel_req;
  logic [47:0] addr_req;
  logic [15:0] bus;
  logic        cs_biu;
  logic [1:0]  sel_biu;
  logic [15:0] addr_biu;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [15:0] rdata;
  logic        busy;

  typedef struct {
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] rdata;
  } beat_t;

  beat_t sb_q[$];
  int checks = 0;
  int errors = 0;

  assign sel_req  = {sel_arr[2], sel_arr[1], sel_arr[0]};
  assign addr_req = {addr_arr[2], addr_arr[1], addr_arr[0]};
  // The bench's BIU returns a value derived from the address it was given.
  assign bus      = addr_biu ^ 16'hA5A5;

  biu_arbiter #(.TIMEOUT(TIMEOUT), .BURST_MAX(BURST_MAX)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .lock_i      (lock),
    .sel_req_i   (sel_req),
    .addr_req_i  (addr_req),
    .ready_biu_i (ready_en),
    .bus_i       (bus),
    .cs_biu_o    (cs_biu),
    .sel_biu_o   (sel_biu),
    .addr_biu_o  (addr_biu),
    .gnt_o       (gnt),
    .done_o      (done),
    .err_o       (err),
    .rdata_o     (rdata),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push(input int idx);
    beat_t b;
    b.gnt   = 3'(1 << idx);
    b.sel   = sel_arr[idx];
    b.addr  = addr_arr[idx];
    b.rdata = addr_arr[idx] ^ 16'hA5A5;
    sb_q.push_back(b);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
      chk("done_in_gnt", 32'(done & ~gnt), 32'd0);
      if (done != 3'b000) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          chk("done_owner", 32'(done), 32'(e.gnt));
          chk("gnt_owner", 32'(gnt), 32'(e.gnt));
          chk("beat_sel", 32'(sel_biu), 32'(e.sel));
          chk("beat_addr", 32'(addr_biu), 32'(e.addr));
          chk("beat_rdata", 32'(rdata), 32'(e.rdata));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"}, 32'(cs_biu), 32'd0);
    chk({tag, "_sel"}, 32'(sel_biu), 32'd0);
    chk({tag, "_addr"}, 32'(addr_biu), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    req = '0;
    lock = '0;
    ready_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_n, done_n, first_done, iss, err_i, err_n;

    sel_arr[0]  = SEL_FETCH;
    sel_arr[1]  = 2'b01;
    sel_arr[2]  = 2'b10;
    addr_arr[0] = 16'h0010;
    addr_arr[1] = 16'h2004;
    addr_arr[2] = 16'h3F08;

    // Reset values while reset is held.
    @(negedge clk);
    #2;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single fetch beat; owner drops req during ISSUE.
    do_reset();
    push(0);
    @(posedge clk);
    #1;
    req = 3'b001;
    cs_n = 0;
    done_n = 0;
    first_done = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      if (cs_biu) cs_n++;
      if (done[0]) begin
        done_n++;
        if (first_done < 0) first_done = i;
      end
      if (i == 1) begin
        chk("t1_issue_addr", 32'(addr_biu), 32'h0010);
        chk("t1_issue_gnt", 32'(gnt), 32'd1);
        req = 3'b000;
      end
    end
    chk("t1_cs_cycles", 32'(cs_n), 32'd2);
    chk("t1_done_count", 32'(done_n), 32'd1);
    chk("t1_done_latency", 32'(first_done), 32'd3);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Round-robin across all three requesters.
    do_reset();
    push(0); push(1); push(2); push(0);
    @(posedge clk);
    #1;
    req = 3'b111;
    drain("t2_drain", 100);
    req = 3'b000;
    repeat (6) @(negedge clk);

    // Locked fetch burst is capped at BURST_MAX beats, then EXU gets the bus.
    do_reset();
    for (int i = 0; i < BURST_MAX; i++) push(0);
    push(1);
    @(posedge clk);
    #1;
    req = 3'b011;
    lock = 3'b001;
    drain("t3_drain", 150);
    req = 3'b000;
    lock = 3'b000;
    repeat (6) @(negedge clk);

    // Timeout abort with ready_biu held low.
    do_reset();
    ready_en = 1'b0;
    @(posedge clk);
    #1;
    req = 3'b100;
    iss = -1;
    err_i = -1;
    err_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (cs_biu && iss < 0) begin
        iss = i;
        req = 3'b000;
      end
      if (err) begin
        err_n++;
        if (err_i < 0) begin
          err_i = i;
          chk("t4_err_busy", 32'(busy), 32'd0);
          chk("t4_err_gnt", 32'(gnt), 32'd0);
          chk("t4_err_cs", 32'(cs_biu), 32'd0);
          chk("t4_err_done", 32'(done), 32'd0);
          chk("t4_err_rdata", 32'(rdata), 32'd0);
        end
      end
      if (err_i >= 0 && i == err_i + 1) chk("t4_idle_after", 32'(busy), 32'd0);
    end
    // One ISSUE cycle followed by TIMEOUT wait cycles, then the pulse.
    chk("t4_err_delay", 32'(err_i - iss), 32'(TIMEOUT + 1));
    chk("t4_err_count", 32'(err_n), 32'd1);
    // Ready with no beat in flight must not produce a done.
    ready_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset asserted mid-WAIT, then normal service afterwards.
    do_reset();
    ready_en = 1'b0;
    @(posedge clk);
    #1;
    req = 3'b001;
    repeat (4) @(negedge clk);
    #2;
    chk("t5_cs_before", 32'(cs_biu), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    req = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    push(1);
    @(posedge clk);
    #1;
    req = 3'b010;
    drain("t5_drain", 50);
    req = 3'b000;
    repeat (6) @(negedge clk);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_arbiter.md
BIU_ARBITER -- requirements
Module: biu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max WAIT cycles before abort.
REQ-002 Parameter BURST_MAX, default 4: max consecutive locked beats per ownership.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-005 req  in  3  per-requester request; bit0 = fetch, bit1 = execute, bit2 = timer/GPIO.
REQ-006 lock  in  3  per-requester "keep grant for next beat", sampled at beat completion.
REQ-007 sel_req  in  6  2-bit BIU select per requester; requester i uses [2i+1:2i].
REQ-008 addr_req  in  48  16-bit address per requester; requester i uses [16i+15:16i].
REQ-009 ready_biu  in  1  BIU beat-complete strobe.
REQ-010 bus  in  16  BIU read data.
REQ-011 cs_biu  out  1  BIU chip select.
REQ-012 sel_biu  out  2  BIU select, copied from the granted requester.
REQ-013 addr_biu  out  16  BIU address, copied from the granted requester.
REQ-014 gnt  out  3  one-hot current owner; 0 when idle.
REQ-015 done  out  3  one-cycle pulse to the owner on beat completion.
REQ-016 err  out  1  one-cycle pulse on timeout abort.
REQ-017 rdata  out  16  bus value registered at beat completion.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and HOLD; all outputs SHALL be registered.
REQ-020 IDLE: cs_biu=0 and gnt=0; if req is non-zero, the FSM SHALL latch the round-robin winner into gnt, sel_biu and addr_biu and go to ISSUE on the next edge.
REQ-021 Round-robin: search starts at (last_owner+1) mod 3; last_owner is reset to 2, so after reset fetch has the highest priority.
REQ-022 ISSUE: cs_biu=1 for one cycle, reset timeout counter to 0, then go to WAIT.
REQ-023 WAIT: cs_biu, sel_biu and addr_biu SHALL be held; the timeout counter increments each cycle in which ready_biu=0.
REQ-024 WAIT with ready_biu=1: capture bus into rdata, pulse done for the owner, increment the beat counter, go to HOLD.
REQ-025 HOLD: cs_biu=0; if lock of the owner is 1 and beats < BURST_MAX, the FSM SHALL re-latch that owner's sel_req and addr_req and go to ISSUE; otherwise it SHALL update last_owner, clear gnt and the beat counter, and go to IDLE.
REQ-026 Minimum beat latency: request seen in IDLE, then ISSUE, then WAIT; done no earlier than 3 cycles after req rises, given ready_biu=1 on the first WAIT cycle.
REQ-027 Timeout: a counter reaching TIMEOUT in WAIT SHALL pulse err, SHALL NOT pulse done, SHALL leave rdata unchanged, SHALL force release and go to IDLE.
REQ-028 An owner dropping req during ISSUE or WAIT SHALL NOT abort the beat; done still pulses.
REQ-029 A requester asserting req while another owns the BIU SHALL wait; no preemption.
REQ-030 When BURST_MAX is reached with lock still high, the FSM SHALL release, and the owner SHALL rank last in the next arbitration.
REQ-031 A ready_biu asserted outside WAIT SHALL be ignored.
REQ-032 gnt SHALL be one-hot or zero in every cycle; done ⊆ gnt.

Reset
REQ-033 While reset=0: state=IDLE, cs_biu=0, sel_biu=0, addr_biu=0, gnt=0, done=0, err=0, rdata=0, busy=0, beat and timeout counters=0, last_owner=2.
REQ-034 Reset asserted mid-beat SHALL drop cs_biu immediately (asynchronously); no done is issued for the aborted beat.

Structure
REQ-035 The shared package SHALL hold the state encoding, requester index constants (FCU=0, EXU=1, PER=2) and the BIU sel code FETCH=2'b11.
REQ-036 A sub-module rr_pick SHALL be combinational: inputs req[2:0] and last_owner; output a one-hot winner.

Verification
REQ-037 Reset, then req=3'b001, sel=11, addr=0x0010, ready_biu=1 on the first WAIT cycle -> cs_biu=1 for 2 cycles, addr_biu=0x0010, done[0] pulses once, rdata=bus.
REQ-038 req=3'b111 held, lock=0 -> grant order 0,1,2,0 across four beats.
REQ-039 Fetch lock=1 for 6 beats with req[1]=1 -> 4 fetch beats, then gnt=3'b010.
REQ-040 ready_biu held 0 with TIMEOUT=16 -> err pulses 16 cycles after ISSUE, no done, FSM in IDLE next cycle.
REQ-041 reset=0 asserted during WAIT -> cs_biu=0 in the same cycle, all outputs at reset values, a new request after release is served normally.
